mem_responder: RTL

- Memory-side responder for the pipeline's memory request interface; it is the target that the memory-controller FSM (IDLE/MEMREAD/RESTART) talks to.
- Samples chip-select requests, inserts a programmable number of wait states, then performs a word read or a byte-masked write on an internal single-port array.
- Completes every accepted request with a one-cycle ready pulse, plus an error flag for bad addresses.
- After reset it runs an INIT sweep that zeroes the array, so the controller's STARTUP states see a deterministic memory.

---
 rtl/mem_responder_pkg.sv | 17 +
 rtl/mem_array.sv | 18 +
 rtl/mem_responder.sv | 77 +++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state, request and error-cause definitions for the memory responder
package mem_responder_pkg;
  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} resp_state_t;
  typedef struct packed {
    logic        MemRead;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
  function automatic logic [1:0] err_cause(input logic [31:0] addr, input int depth);
    return (addr[1:0] != 2'b00) ? ERR_MISALIGN :
           (32'(addr[31:2]) >= 32'(depth)) ? ERR_RANGE : ERR_NONE;
  endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x 32 single-port RAM, byte-enabled sync write, combinational read (ports: clk, we, addr, wdata, be, rdata)
module mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: request target with INIT clear sweep, programmable wait states and registered ready/err/rdata (ports: clk, rst_n, CS, MemRead, addr, wdata, be -> rdata, ready, err, busy)
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CS,
  input  logic        MemRead,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  resp_state_t   state, state_nxt;
  mem_req_t      req;
  logic [AW-1:0] cnt;
  logic [3:0]    wcnt;
  logic          bad;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;
  logic [3:0]    ram_be;
  assign busy = state != IDLE;
  assign bad  = err_cause(req.addr, DEPTH) != ERR_NONE;
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    state_nxt = (cnt == AW'(DEPTH - 1)) ? IDLE : INIT;
      IDLE:    state_nxt = !CS ? IDLE : (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    state_nxt = (wcnt == 4'd0) ? RESP : WAIT;
      default: state_nxt = IDLE;
    endcase
  end
  // INIT owns the RAM port for the clear sweep; otherwise the latched request does,
  // and only a good-address write in RESP may commit.
  always_comb begin
    ram_we    = (state == INIT) || (state == RESP && !req.MemRead && !bad);
    ram_addr  = (state == INIT) ? cnt : req.addr[AW+1:2];
    ram_wdata = (state == INIT) ? '0 : req.wdata;
    ram_be    = (state == INIT) ? 4'hF : req.be;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
      wcnt  <= '0;
      req   <= '0;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      ready <= state == RESP;
      err   <= state == RESP && bad;
      rdata <= (state == RESP && req.MemRead && !bad) ? ram_rdata : '0;
      if (state == INIT) cnt <= cnt + 1'b1;
      if (state == IDLE && CS) begin
        req  <= '{MemRead, addr, wdata, be};
        wcnt <= 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
      end else if (state == WAIT) wcnt <= wcnt - 1'b1;
    end
  mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .be   (ram_be),
    .rdata(ram_rdata)
  );
endmodule
